morra_partita_ctrl: RTL and testbench

Match controller for the Morra Cinese (rock-paper-scissors) game. It starts a match on `INIZIA` and programs the match length. Each cycle it samples both players' moves, rejects illegal manches and keeps the scores. It declares the match result on a margin or manche-limit rule. The per-manche judgement is a combinational sub-module. This block sequences it, owns all match state and drives the registered `MANCHE`/`PARTITA` outputs.

---
 rtl/morra_pkg.sv | 29 ++
 rtl/morra_giudice.sv | 25 ++
 rtl/morra_partita_ctrl.sv | 116 +++++++++++
 tb/tb_morra_partita_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/morra_pkg.sv
// Shared constants, state type and helpers for the Morra Cinese match controller.
package morra_pkg;

    localparam logic [1:0] M_NONE    = 2'b00;
    localparam logic [1:0] M_SASSO   = 2'b01;
    localparam logic [1:0] M_CARTA   = 2'b10;
    localparam logic [1:0] M_FORBICE = 2'b11;

    localparam logic [1:0] R_NONE     = 2'b00;
    localparam logic [1:0] R_P1       = 2'b01;
    localparam logic [1:0] R_P2       = 2'b10;
    localparam logic [1:0] R_PAREGGIO = 2'b11;

    localparam logic [4:0] BASE_MANCHE = 5'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GIOCO = 2'd1,
        FINE  = 2'd2
    } stato_t;

    // True when move a beats move b (both assumed non-NONE and different).
    function automatic logic batte(input logic [1:0] a, input logic [1:0] b);
        return (a == M_SASSO   && b == M_FORBICE) ||
               (a == M_FORBICE && b == M_CARTA)   ||
               (a == M_CARTA   && b == M_SASSO);
    endfunction

endpackage

// File: rtl/morra_giudice.sv
// Combinational judge for a single manche: legality and winner.
module morra_giudice
    import morra_pkg::*;
(
    input  logic [1:0] primo_i,
    input  logic [1:0] secondo_i,
    input  logic [1:0] ult_vinc_i,
    input  logic [1:0] ult_mossa_i,
    output logic       valido_o,
    output logic [1:0] esito_o
);

    logic mosse_ok;
    logic ripete;

    assign mosse_ok = (primo_i != M_NONE) && (secondo_i != M_NONE);
    // The previous winner may not win twice with the same move.
    assign ripete   = ((ult_vinc_i == R_P1) && (primo_i   == ult_mossa_i)) ||
                      ((ult_vinc_i == R_P2) && (secondo_i == ult_mossa_i));
    assign valido_o = mosse_ok && !ripete;

    assign esito_o = (primo_i == secondo_i)    ? R_PAREGGIO :
                     batte(primo_i, secondo_i) ? R_P1       : R_P2;

endmodule

// File: rtl/morra_partita_ctrl.sv
// Match sequencer: owns scores, manche count and end-of-match decision.
module morra_partita_ctrl
    import morra_pkg::*;
#(
    parameter int unsigned MIN_MANCHE = 4,
    parameter int unsigned MARGINE    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    input  logic       INIZIA,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA
);

    localparam logic [4:0] MIN_C  = 5'(MIN_MANCHE);
    localparam logic [4:0] MARG_C = 5'(MARGINE);

    stato_t     stato_q, stato_d;
    logic [4:0] max_q, max_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] s1_q, s1_d;
    logic [4:0] s2_q, s2_d;
    logic [1:0] ult_vinc_q, ult_vinc_d;
    logic [1:0] ult_mossa_q, ult_mossa_d;
    logic [1:0] manche_q, manche_d;
    logic [1:0] partita_q, partita_d;

    logic       valido;
    logic [1:0] esito;
    logic [4:0] diff;

    morra_giudice u_giudice (
        .primo_i     (PRIMO),
        .secondo_i   (SECONDO),
        .ult_vinc_i  (ult_vinc_q),
        .ult_mossa_i (ult_mossa_q),
        .valido_o    (valido),
        .esito_o     (esito)
    );

    always_comb begin
        stato_d     = stato_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        ult_vinc_d  = ult_vinc_q;
        ult_mossa_d = ult_mossa_q;
        manche_d    = R_NONE;
        partita_d   = partita_q;
        diff        = 5'd0;

        if (INIZIA) begin
            stato_d     = GIOCO;
            max_d       = {1'b0, PRIMO, SECONDO} + BASE_MANCHE;
            cnt_d       = 5'd0;
            s1_d        = 5'd0;
            s2_d        = 5'd0;
            ult_vinc_d  = R_NONE;
            ult_mossa_d = M_NONE;
            partita_d   = R_NONE;
        end else if (stato_q == GIOCO && valido) begin
            manche_d = esito;
            cnt_d    = cnt_q + 5'd1;
            if (esito == R_P1) begin
                s1_d        = s1_q + 5'd1;
                ult_mossa_d = PRIMO;
            end else if (esito == R_P2) begin
                s2_d        = s2_q + 5'd1;
                ult_mossa_d = SECONDO;
            end
            ult_vinc_d = (esito == R_PAREGGIO) ? R_NONE : esito;

            // End check works on the post-manche values.
            diff = (s1_d >= s2_d) ? (s1_d - s2_d) : (s2_d - s1_d);
            if (cnt_d >= MIN_C && diff >= MARG_C) begin
                partita_d = (s1_d > s2_d) ? R_P1 : R_P2;
                stato_d   = FINE;
            end else if (cnt_d == max_q) begin
                partita_d = (s1_d > s2_d) ? R_P1 :
                            (s2_d > s1_d) ? R_P2 : R_PAREGGIO;
                stato_d   = FINE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stato_q     <= IDLE;
            max_q       <= 5'd0;
            cnt_q       <= 5'd0;
            s1_q        <= 5'd0;
            s2_q        <= 5'd0;
            ult_vinc_q  <= R_NONE;
            ult_mossa_q <= M_NONE;
            manche_q    <= R_NONE;
            partita_q   <= R_NONE;
        end else begin
            stato_q     <= stato_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            ult_vinc_q  <= ult_vinc_d;
            ult_mossa_q <= ult_mossa_d;
            manche_q    <= manche_d;
            partita_q   <= partita_d;
        end
    end

    assign MANCHE  = manche_q;
    assign PARTITA = partita_q;

endmodule

// File: tb/tb_morra_partita_ctrl.sv
// Self-checking bench: directed match scenarios plus random play against a reference model.
module tb_morra_partita_ctrl;

    localparam int MIN_M = 4;
    localparam int MARG  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       INIZIA;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    int    n_cmp = 0;
    int    n_err = 0;
    string fase  = "init";

    // Reference model: a match in progress flag plus plain integer tallies.
    bit m_play;
    int m_manche, m_partita;
    int m_s1, m_s2, m_cnt, m_max, m_lw, m_lm;

    morra_partita_ctrl #(.MIN_MANCHE(MIN_M), .MARGINE(MARG)) dut (
        .clk     (clk),
        .rst     (rst),
        .PRIMO   (PRIMO),
        .SECONDO (SECONDO),
        .INIZIA  (INIZIA),
        .MANCHE  (MANCHE),
        .PARTITA (PARTITA)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", fase, tag, obs, exp, $time);
        end
    endtask

    task automatic modello(input bit r, input bit i, input int p, input int s);
        int d, w, gap;
        if (r) begin
            m_play = 0; m_manche = 0; m_partita = 0;
            m_s1 = 0; m_s2 = 0; m_cnt = 0; m_max = 0; m_lw = 0; m_lm = 0;
        end else if (i) begin
            m_play = 1; m_manche = 0; m_partita = 0;
            m_max = p * 4 + s + 4;
            m_s1 = 0; m_s2 = 0; m_cnt = 0; m_lw = 0; m_lm = 0;
        end else if (!m_play) begin
            m_manche = 0;
        end else begin
            m_manche = 0;
            if (p != 0 && s != 0 && !(m_lw == 1 && p == m_lm) && !(m_lw == 2 && s == m_lm)) begin
                // Moves 1,2,3 form a cycle: (p - s) mod 3 == 1 means p wins.
                d = (p - s + 3) % 3;
                w = (d == 0) ? 3 : (d == 1) ? 1 : 2;
                m_cnt++;
                m_manche = w;
                if (w == 1) begin m_s1++; m_lw = 1; m_lm = p; end
                else if (w == 2) begin m_s2++; m_lw = 2; m_lm = s; end
                else m_lw = 0;
                gap = (m_s1 > m_s2) ? m_s1 - m_s2 : m_s2 - m_s1;
                if (m_cnt >= MIN_M && gap >= MARG) begin
                    m_partita = (m_s1 > m_s2) ? 1 : 2;
                    m_play = 0;
                end else if (m_cnt == m_max) begin
                    m_partita = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
                    m_play = 0;
                end
            end
        end
    endtask

    task automatic ciclo(input bit r, input bit i, input logic [1:0] p, input logic [1:0] s);
        rst = r; INIZIA = i; PRIMO = p; SECONDO = s;
        @(posedge clk);
        modello(r, i, int'(p), int'(s));
        #1;
        verifica("manche", {6'd0, MANCHE}, 8'(m_manche));
        verifica("partita", {6'd0, PARTITA}, 8'(m_partita));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; INIZIA = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
        @(negedge clk);

        fase = "reset";
        ciclo(1, 0, 2'b01, 2'b11);
        verifica("manche_rst", {6'd0, MANCHE}, 8'd0);
        verifica("partita_rst", {6'd0, PARTITA}, 8'd0);

        fase = "idle";
        repeat (3) ciclo(0, 0, 2'b01, 2'b11);
        verifica("manche_idle", {6'd0, MANCHE}, 8'd0);

        fase = "margine";
        ciclo(0, 1, 2'b00, 2'b00);
        ciclo(0, 0, 2'b01, 2'b11);
        ciclo(0, 0, 2'b10, 2'b01);
        ciclo(0, 0, 2'b11, 2'b10);
        ciclo(0, 0, 2'b01, 2'b11);
        verifica("partita_p1", {6'd0, PARTITA}, 8'd1);
        ciclo(0, 0, 2'b10, 2'b01);
        verifica("dopo_fine", {6'd0, MANCHE}, 8'd0);

        fase = "ripeti";
        ciclo(0, 1, 2'b00, 2'b00);
        ciclo(0, 0, 2'b01, 2'b11);
        ciclo(0, 0, 2'b01, 2'b10);
        verifica("ripeti_inv", {6'd0, MANCHE}, 8'd0);
        ciclo(0, 0, 2'b10, 2'b01);
        verifica("ripeti_ok", {6'd0, MANCHE}, 8'd1);

        fase = "pareggio";
        ciclo(0, 1, 2'b00, 2'b00);
        repeat (4) ciclo(0, 0, 2'b01, 2'b01);
        verifica("partita_tie", {6'd0, PARTITA}, 8'd3);

        fase = "lunga";
        ciclo(0, 1, 2'b11, 2'b11);
        for (int k = 0; k < 19; k++) begin
            if (k % 2 == 0) ciclo(0, 0, 2'b01, 2'b11);
            else            ciclo(0, 0, 2'b11, 2'b01);
            if (k == 17) verifica("partita_18", {6'd0, PARTITA}, 8'd0);
        end
        verifica("partita_19", {6'd0, PARTITA}, 8'd1);

        fase = "restart";
        ciclo(0, 1, 2'b01, 2'b10);
        ciclo(0, 0, 2'b01, 2'b11);
        ciclo(0, 0, 2'b00, 2'b10);
        verifica("mossa_nulla", {6'd0, MANCHE}, 8'd0);
        ciclo(0, 1, 2'b00, 2'b00);
        verifica("restart_part", {6'd0, PARTITA}, 8'd0);
        ciclo(0, 0, 2'b10, 2'b01);
        ciclo(1, 1, 2'b10, 2'b01);
        ciclo(0, 0, 2'b10, 2'b01);
        verifica("rst_idle", {6'd0, MANCHE}, 8'd0);

        fase = "random";
        for (int n = 0; n < 4000; n++) begin
            bit r, i;
            logic [1:0] p, s;
            r = ($urandom_range(0, 99) == 0);
            i = m_play ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            s = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            ciclo(r, i, p, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
